jk_bank_sequencer: RTL and testbench
====================================

# jk_bank_sequencer

Sequencer and two-port arbiter for a shared bank of WIDTH JK flip-flops. Two requesters, A and B, issue SET / CLEAR / TOGGLE / HOLD commands on masked bits over valid/ready handshakes. The block grants one requester at a time with round-robin priority and drives the bank's per-bit j/k inputs for the required number of cycles. It contains the JK bank itself and exposes q as the shared state, so it is the single owner of the bank in the design.

## Interface
- WIDTH, 4, number of JK flip-flops in the bank
- CNT_W, 4, width of the toggle burst-length field
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a_valid  input  1  requester A command valid
- a_ready  output  1  requester A command accepted this cycle when a_valid is also high
- a_op  input  2  A opcode: 00 HOLD, 01 SET, 10 CLEAR, 11 TOGGLE
- a_mask  input  WIDTH  A bit-select mask
- a_len  input  CNT_W  A toggle burst length minus one; ignored for other opcodes
- b_valid, b_ready, b_op, b_mask, b_len  same as A, for requester B
- j  output  WIDTH  registered j drive to the bank
- k  output  WIDTH  registered k drive to the bank
- q  output  WIDTH  bank state
- busy  output  1  high while a command is being applied
- done  output  1  one-cycle pulse when a command completes
- done_id  output  1  requester whose command completed (0 = A, 1 = B); valid while done is high

## Operation
- States: IDLE, APPLY.
- Reset values: state IDLE; q = 0; j = 0; k = 0; busy = 0; done = 0; done_id = 0; round-robin pointer set to favour A.
- Arbitration applies only in IDLE and is combinational:
  - Only one valid: that requester is granted.
  - Both valid: the requester not served last is granted.
  - a_ready = IDLE & grant_a; b_ready = IDLE & grant_b.
  - Both readys are low in APPLY.
  - Only one ready is ever high in a cycle.
- Accept: the granted requester's valid & ready is true at a rising edge. At that edge the block:
  - latches op, mask, len and requester id;
  - loads j/k per bit from the opcode: SET gives j = mask, k = 0; CLEAR gives j = 0, k = mask; TOGGLE gives j = k = mask; HOLD gives j = k = 0;
  - loads the remaining-cycle counter: len for TOGGLE, 0 otherwise;
  - moves to APPLY and updates the round-robin pointer to the other requester.
- Bank: each bit follows JK semantics at every rising edge using the current j/k values. j=0,k=0 holds; j=1,k=0 sets; j=0,k=1 clears; j=1,k=1 toggles.
- APPLY, at each edge:
  - If the counter is 0: clear j/k to 0, return to IDLE, pulse done with the latched id.
  - Otherwise: decrement the counter and keep j/k unchanged.
- A command with mask = 0 still occupies the bank for its full duration and still pulses done; q does not change.
- Requesters must hold op, mask and len stable while valid is high and ready is low. Dropping valid before acceptance is allowed; no command is recorded.

## Timing
- Accept at edge E0; j/k valid after E0; q first changes at E1.
- SET, CLEAR and HOLD complete at E1: j/k = 0, state IDLE, and done high for the cycle after E1.
- TOGGLE with len = L: q toggles at E1 … E(L+1), giving L+1 toggles in total. j/k clear and done pulses after E(L+1).
- The next accept can occur at the edge after the done cycle begins, because done and ready may be high together. Peak throughput is one SET/CLEAR per 2 cycles.
- busy = (state == APPLY), from E0 until the completing edge.
- rst asserted mid-command: immediate abort. q, j, k, done and state return to their reset values with no done pulse; the pointer returns to favour A.
- A valid held through reset is considered in the first IDLE cycle after release.

## Test plan
- Reset, then A SET with mask 0101: a_ready=1 in the accept cycle, j=0101 and k=0000 for one cycle, q=0101 after E1, done=1 and done_id=0 for one cycle.
- A CLEAR with mask 0001 from q=0101: k=0001 for one cycle, q=0100, busy high for exactly 1 cycle.
- A and B valid together, both SET, every cycle for 4 commands: grants alternate A, B, A, B starting with A; done_id sequence is 0, 1, 0, 1; a_ready and b_ready are never high together.
- B TOGGLE with mask 1111 and len 2 from q=0000: q goes 1111, 0000, 1111 on three successive edges; j=k=1111 for 3 cycles; then done with done_id=1 and j=k=0.
- TOGGLE with mask 0000 and len 3: busy for 4 cycles, q unchanged, done pulses once.
- Assert rst one cycle into a TOGGLE with len 5: q=0, j=k=0, busy=0 immediately, and no done pulse follows.

Source files
------------

// File: rtl/jk_bank_sequencer.sv
// ----------------------------------------------------------------------------
// jk_bank_sequencer
//
// Owns a bank of WIDTH JK flip-flops. Two requesters, A and B, issue
// masked HOLD / SET / CLEAR / TOGGLE commands over valid/ready handshakes.
// A round-robin arbiter grants one requester per command. The block then
// drives the bank's j/k inputs for the required number of cycles.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   a_valid/a_ready          requester A handshake
//   a_op/a_mask/a_len        A opcode (00 HOLD, 01 SET, 10 CLEAR, 11 TOGGLE),
//                            bit mask, toggle burst length minus one
//   b_*                      same as A, for requester B
//   j, k                     registered drive into the bank
//   q                        bank state
//   busy                     high while a command is being applied
//   done, done_id            one-cycle completion pulse, completing requester
//                            (0 = A, 1 = B)
// ----------------------------------------------------------------------------
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             a_valid,
    output logic             a_ready,
    input  logic [1:0]       a_op,
    input  logic [WIDTH-1:0] a_mask,
    input  logic [CNT_W-1:0] a_len,

    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_op,
    input  logic [WIDTH-1:0] b_mask,
    input  logic [CNT_W-1:0] b_len,

    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             done_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_ptr;      // 0: A favoured on a tie, 1: B favoured
    logic [CNT_W-1:0] r_cnt;      // remaining APPLY cycles after this one
    logic             r_id;
    logic             r_done;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_q;

    logic             w_idle;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_accept;
    logic             w_sel_b;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_mask;
    logic [CNT_W-1:0] w_len;
    logic [WIDTH-1:0] w_j_load;
    logic [WIDTH-1:0] w_k_load;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester always wins. On a tie the pointer
    // decides, so the one not served last goes first.
    // ------------------------------------------------------------------
    assign w_idle    = (r_state == IDLE);
    assign w_grant_a = a_valid & (~b_valid | ~r_ptr);
    assign w_grant_b = b_valid & (~a_valid |  r_ptr);

    assign a_ready   = w_idle & w_grant_a;
    assign b_ready   = w_idle & w_grant_b;

    assign w_accept  = (a_valid & a_ready) | (b_valid & b_ready);
    assign w_sel_b   = b_ready;

    assign w_op      = w_sel_b ? b_op   : a_op;
    assign w_mask    = w_sel_b ? b_mask : a_mask;
    assign w_len     = w_sel_b ? b_len  : a_len;

    // Opcode to per-bit j/k drive.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_j_load = '0;
        w_k_load = '0;
        case (w_op)
            OP_SET:    w_j_load = w_mask;
            OP_CLEAR:  w_k_load = w_mask;
            OP_TOGGLE: begin
                w_j_load = w_mask;
                w_k_load = w_mask;
            end
            default: ; // OP_HOLD: both stay zero
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer, JK bank and registered outputs.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
            r_id    <= 1'b0;
            r_done  <= 1'b0;
            r_j     <= '0;
            r_k     <= '0;
            r_q     <= '0;
        end else begin
            // JK bank: set where j, keep where ~k. This gives hold, set,
            // clear and toggle in a single expression.
            r_q    <= (r_j & ~r_q) | (~r_k & r_q);
            r_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_sel_b;
                        r_j     <= w_j_load;
                        r_k     <= w_k_load;
                        r_cnt   <= (w_op == OP_TOGGLE) ? w_len : '0;
                        r_ptr   <= ~w_sel_b;
                        r_state <= APPLY;
                    end
                end

                APPLY: begin
                    if (r_cnt == '0) begin
                        r_j     <= '0;
                        r_k     <= '0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign j       = r_j;
    assign k       = r_k;
    assign q       = r_q;
    assign busy    = (r_state == APPLY);
    assign done    = r_done;
    // r_id only changes at accept, so it stays stable through the done cycle.
    assign done_id = r_id;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// ----------------------------------------------------------------------------
// tb_jk_bank_sequencer
//
// Directed self-checking bench for jk_bank_sequencer (WIDTH = 4, CNT_W = 4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_jk_bank_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic [1:0] a_op, b_op;
    logic [3:0] a_mask, b_mask;
    logic [3:0] a_len, b_len;
    logic [3:0] j, k, q;
    logic       busy, done, done_id;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jk_bank_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_op    (a_op),
        .a_mask  (a_mask),
        .a_len   (a_len),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_op    (b_op),
        .b_mask  (b_mask),
        .b_len   (b_len),
        .j       (j),
        .k       (k),
        .q       (q),
        .busy    (busy),
        .done    (done),
        .done_id (done_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        a_valid = 1'b0; a_op = 2'b00; a_mask = 4'h0; a_len = 4'h0;
        b_valid = 1'b0; b_op = 2'b00; b_mask = 4'h0; b_len = 4'h0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_q",     q,       0);
        check("rst_j",     j,       0);
        check("rst_k",     k,       0);
        check("rst_busy",  busy,    0);
        check("rst_done",  done,    0);
        check("rst_id",    done_id, 0);
        check("rst_ardy",  a_ready, 0);
        rst = 1'b0;
        tick();

        // ---------------- A SET 0101 ----------------
        a_valid = 1'b1; a_op = 2'b01; a_mask = 4'b0101;
        #1;
        check("set_ardy",  a_ready, 1);
        check("set_brdy",  b_ready, 0);
        tick();                                   // E0
        a_valid = 1'b0;
        #1;
        check("set_j",     j,    4'b0101);
        check("set_k",     k,    4'b0000);
        check("set_busy",  busy, 1);
        check("set_q0",    q,    4'b0000);
        check("set_ardy2", a_ready, 0);
        tick();                                   // E1
        check("set_q",     q,    4'b0101);
        check("set_jclr",  j,    0);
        check("set_done",  done, 1);
        check("set_id",    done_id, 0);
        check("set_busy2", busy, 0);
        tick();
        check("set_done2", done, 0);

        // ---------------- A CLEAR 0001 ----------------
        a_valid = 1'b1; a_op = 2'b10; a_mask = 4'b0001;
        #1;
        check("clr_ardy",  a_ready, 1);
        tick();                                   // E0
        a_valid = 1'b0;
        #1;
        check("clr_k",     k,    4'b0001);
        check("clr_j",     j,    4'b0000);
        check("clr_busy",  busy, 1);
        tick();                                   // E1
        check("clr_q",     q,    4'b0100);
        check("clr_busy2", busy, 0);
        check("clr_done",  done, 1);
        check("clr_kclr",  k,    0);
        tick();

        // ------- both valid, both SET, held through reset -------
        rst = 1'b1;
        a_valid = 1'b1; a_op = 2'b01; a_mask = 4'b0001;
        b_valid = 1'b1; b_op = 2'b01; b_mask = 4'b0010;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_ardy%0d", i), a_ready, (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr_brdy%0d", i), b_ready, (i % 2 == 1) ? 1 : 0);
            check($sformatf("rr_excl%0d", i), a_ready & b_ready, 0);
            if (i > 0) begin
                check($sformatf("rr_done%0d", i), done, 1);
                check($sformatf("rr_id%0d", i), done_id, ((i - 1) % 2 == 1) ? 1 : 0);
            end
            tick();                               // accept edge
            check($sformatf("rr_busy%0d", i), busy, 1);
            check($sformatf("rr_rdy_apply%0d", i), a_ready | b_ready, 0);
            tick();                               // completing edge
        end
        check("rr_done_last", done,    1);
        check("rr_id_last",   done_id, 1);
        check("rr_q",         q,       4'b0011);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        // ---------------- B TOGGLE 1111 len 2 from 0000 ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("tg_q_init", q, 0);
        b_valid = 1'b1; b_op = 2'b11; b_mask = 4'b1111; b_len = 4'd2;
        #1;
        check("tg_brdy", b_ready, 1);
        tick();                                   // E0
        b_valid = 1'b0;
        #1;
        check("tg_j0", j, 4'b1111);
        check("tg_k0", k, 4'b1111);
        check("tg_q0", q, 4'b0000);
        tick();                                   // E1
        check("tg_q1", q, 4'b1111);
        check("tg_j1", j, 4'b1111);
        check("tg_done1", done, 0);
        tick();                                   // E2
        check("tg_q2", q, 4'b0000);
        check("tg_k2", k, 4'b1111);
        tick();                                   // E3
        check("tg_q3",    q, 4'b1111);
        check("tg_j3",    j, 0);
        check("tg_k3",    k, 0);
        check("tg_done",  done, 1);
        check("tg_id",    done_id, 1);
        check("tg_busy",  busy, 0);
        tick();
        check("tg_done_off", done, 0);

        // ---------------- A TOGGLE mask 0000 len 3 ----------------
        a_valid = 1'b1; a_op = 2'b11; a_mask = 4'b0000; a_len = 4'd3;
        tick();                                   // E0
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("z_busy%0d", i), busy, 1);
            check($sformatf("z_done%0d", i), done, 0);
            check($sformatf("z_q%0d", i),    q,    4'b1111);
            tick();
        end
        check("z_busy_end", busy,    0);
        check("z_done",     done,    1);
        check("z_id",       done_id, 0);
        check("z_q_end",    q,       4'b1111);
        tick();
        check("z_done_once", done, 0);

        // ---------------- reset mid TOGGLE len 5 ----------------
        a_valid = 1'b1; a_op = 2'b11; a_mask = 4'b1111; a_len = 4'd5;
        tick();                                   // E0
        a_valid = 1'b0;
        tick();                                   // E1
        check("ab_q_mid", q, 4'b0000);            // first toggle from 1111
        check("ab_busy_mid", busy, 1);
        rst = 1'b1;
        #1;
        check("ab_q",    q,    0);
        check("ab_j",    j,    0);
        check("ab_k",    k,    0);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("ab_nodone%0d", i), done, 0);
        end
        check("ab_q_end", q, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net: the directed sequence is short; never run away.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
